// File: rtl/bus_generator_arbiter_pkg.sv
// Shared types and constants for the shared-bus round-robin arbiter.
package bus_generator_arbiter_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_POP, ST_PUSH, ST_GAP} state_e;
  localparam int ID_W = 8;
  localparam logic [ID_W-1:0] BCAST_DEF = 8'hFF;
endpackage

// File: rtl/bus_generator_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first requester strictly after i_ptr, wrapping.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_gnt,
  output logic [IW-1:0] o_idx,
  output logic          o_any
);
  logic w_found;
  int   w_c;

  assign o_any = |i_req;

  always_comb begin
    o_gnt   = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_c     = 0;
    // k = N revisits the pointer itself, so a lone requester at ptr still wins
    for (int k = 1; k <= N; k++) begin
      w_c = int'(i_ptr) + k;
      if (w_c >= N) w_c = w_c - N;
      if (!w_found && i_req[w_c]) begin
        w_found     = 1'b1;
        o_gnt[w_c]  = 1'b1;
        o_idx       = IW'(w_c);
      end
    end
  end
endmodule

// File: rtl/bus_generator_arbiter.sv
// Shared-bus model: per bus, grant one pending device, pop its head, push to the decoded destination.
module bus_generator_arbiter
  import bus_generator_arbiter_pkg::*;
#(
  parameter int              bits      = 1,
  parameter int              drvrs     = 4,
  parameter int              pckg_sz   = 16,
  parameter logic [ID_W-1:0] broadcast = BCAST_DEF
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic [bits-1:0][drvrs-1:0]              pndng,
  output logic [bits-1:0][drvrs-1:0]              push,
  output logic [bits-1:0][drvrs-1:0]              pop,
  input  logic [bits-1:0][drvrs-1:0][pckg_sz-1:0] D_pop,
  output logic [bits-1:0][drvrs-1:0][pckg_sz-1:0] D_push
);
  localparam int IW = $clog2(drvrs);

  for (genvar b = 0; b < bits; b++) begin : g_bus
    state_e             r_state, w_next;
    logic [IW-1:0]      r_ptr, w_idx;
    logic [drvrs-1:0]   r_gnt, w_gnt, w_pop, w_push;
    logic               w_any;
    logic [pckg_sz-1:0] r_pkt, r_dpush;
    logic [ID_W-1:0]    w_dest;

    rr_arbiter #(.N(drvrs), .IW(IW)) u_arb (
      .i_req (pndng[b]),
      .i_ptr (r_ptr),
      .o_gnt (w_gnt),
      .o_idx (w_idx),
      .o_any (w_any)
    );

    assign w_dest = r_pkt[pckg_sz-1 -: ID_W];

    always_ff @(posedge clk) begin
      if (reset) r_state <= ST_IDLE;
      else       r_state <= w_next;
    end

    always_comb begin
      w_next = r_state;
      w_pop  = '0;
      w_push = '0;
      case (r_state)
        ST_IDLE: if (w_any) w_next = ST_POP;
        ST_POP: begin
          w_pop  = r_gnt;
          w_next = ST_PUSH;
        end
        ST_PUSH: begin
          // out-of-range IDs and self-addressed packets match no j and are dropped
          for (int j = 0; j < drvrs; j++) begin
            if (w_dest == broadcast) w_push[j] = (r_ptr != IW'(j));
            else                     w_push[j] = (w_dest == ID_W'(j)) && (r_ptr != IW'(j));
          end
          w_next = ST_GAP;
        end
        default: w_next = ST_IDLE;
      endcase
    end

    // grant index doubles as the round-robin pointer
    always_ff @(posedge clk) begin
      if (reset) begin
        r_ptr   <= IW'(drvrs - 1);
        r_gnt   <= '0;
        r_pkt   <= '0;
        r_dpush <= '0;
      end else begin
        if (r_state == ST_IDLE && w_any) begin
          r_ptr <= w_idx;
          r_gnt <= w_gnt;
          r_pkt <= D_pop[b][w_idx];
        end
        if (r_state == ST_POP) r_dpush <= r_pkt;
      end
    end

    assign pop[b]  = w_pop;
    assign push[b] = w_push;
    for (genvar j = 0; j < drvrs; j++) begin : g_dout
      assign D_push[b][j] = r_dpush;
    end
  end
endmodule

// File: tb/tb_bus_generator_arbiter.sv
// Directed bench for bus_generator_arbiter with a queue model of the device FIFOs.
module tb_bus_generator_arbiter;
  logic                   clk = 1'b0;
  logic                   reset = 1'b1;
  logic [0:0][3:0]        pndng;
  logic [0:0][3:0]        push, pop;
  logic [0:0][3:0][15:0]  D_pop, D_push;

  bus_generator_arbiter #(.bits(1), .drvrs(4), .pckg_sz(16), .broadcast(8'hFF)) dut (
    .clk(clk), .reset(reset), .pndng(pndng), .push(push), .pop(pop),
    .D_pop(D_pop), .D_push(D_push)
  );

  always #5 clk = ~clk;

  logic [15:0] q[4][$];
  logic [15:0] popped[$];
  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int          src;
    logic [15:0] data;
    logic [3:0]  exp_pop;
    logic [3:0]  exp_push;
  } vec_t;
  vec_t vt[8];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      pndng[0][i] = (q[i].size() != 0);
      D_pop[0][i] = (q[i].size() != 0) ? q[i][0] : 16'h0000;
    end
  endtask

  // advance one edge, retire any popped heads, present the new heads
  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++)
      if (pop[0][i] === 1'b1 && q[i].size() != 0) popped.push_back(q[i].pop_front());
    drive();
  endtask

  function automatic logic [63:0] rep4(input logic [15:0] d);
    return {d, d, d, d};
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int          npop, npush, got;
    logic [15:0] e;
    logic [3:0]  m;

    vt[0] = '{1, 16'h02AB, 4'b0010, 4'b0100};
    vt[1] = '{3, 16'hFF5A, 4'b1000, 4'b0111};
    vt[2] = '{0, 16'h07CC, 4'b0001, 4'b0000};
    vt[3] = '{2, 16'h0211, 4'b0100, 4'b0000};
    vt[4] = '{0, 16'h0333, 4'b0001, 4'b1000};
    vt[5] = '{2, 16'hFFEE, 4'b0100, 4'b1011};
    vt[6] = '{1, 16'h00AA, 4'b0010, 4'b0001};
    vt[7] = '{3, 16'h0100, 4'b1000, 4'b0010};

    // reset with random pending traffic
    for (int i = 0; i < 4; i++)
      if ($urandom_range(0, 1) == 1) q[i].push_back(16'($urandom));
    drive();
    tick();
    chk("rst_pop", 64'(pop), 64'h0);
    chk("rst_push", 64'(push), 64'h0);
    chk("rst_dpush", 64'(D_push), 64'h0);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) q[i].delete();
    popped.delete();
    drive();
    tick();
    chk("post_rst_pop", 64'(pop), 64'h0);
    chk("post_rst_push", 64'(push), 64'h0);
    chk("post_rst_dpush", 64'(D_push), 64'h0);

    // single-packet vectors
    for (int v = 0; v < 8; v++) begin
      q[vt[v].src].push_back(vt[v].data);
      drive();
      for (int c = 0; c < 10; c++) begin
        tick();
        if (pop[0] != 4'b0000) break;
      end
      chk($sformatf("v%0d_pop", v), 64'(pop), 64'(vt[v].exp_pop));
      tick();
      chk($sformatf("v%0d_push", v), 64'(push), 64'(vt[v].exp_push));
      chk($sformatf("v%0d_dpush", v), 64'(D_push), rep4(vt[v].data));
      tick();
      chk($sformatf("v%0d_gap", v), 64'({pop[0], push[0]}), 64'h0);
      chk($sformatf("v%0d_hold", v), 64'(D_push), rep4(vt[v].data));
    end

    // round-robin with all devices loaded
    popped.delete();
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 8; k++)
        q[i].push_back({8'((i + 1) % 4), 4'(i), 4'(k)});
    drive();
    npop = 0;
    npush = 0;
    for (int c = 0; c < 300 && npush < 32; c++) begin
      tick();
      if (pop[0] != 4'b0000) begin
        chk("rr_pop", 64'(pop), 64'(1 << (npop % 4)));
        npop++;
      end
      if (push[0] != 4'b0000) begin
        e = (popped.size() != 0) ? popped.pop_front() : 16'hxxxx;
        m = 4'b0001 << e[9:8];
        chk("rr_push", 64'(push), 64'(m));
        chk("rr_dpush", 64'(D_push), rep4(e));
        npush++;
      end
    end
    chk("rr_npop", 64'(npop), 64'd32);
    chk("rr_npush", 64'(npush), 64'd32);

    // reset during PUSH: packet discarded, device 0 regains priority
    for (int c = 0; c < 4; c++) tick();
    q[1].push_back(16'h0311);
    drive();
    got = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (pop[0] != 4'b0000) begin got = 1; break; end
    end
    chk("mr_pop", 64'(pop), 64'b0010);
    tick();
    chk("mr_push_cycle", 64'(push), 64'b1000);
    reset = 1'b1;
    q[0].push_back(16'h0244);
    q[2].push_back(16'h0155);
    drive();
    tick();
    chk("mr_after_push", 64'(push), 64'h0);
    chk("mr_after_pop", 64'(pop), 64'h0);
    chk("mr_after_dpush", 64'(D_push), 64'h0);
    reset = 1'b0;
    tick();
    chk("mr_regrant", 64'(pop), 64'b0001);
    tick();
    chk("mr_push2", 64'(push), 64'b0100);
    chk("mr_dpush2", 64'(D_push), rep4(16'h0244));
    for (int c = 0; c < 20; c++) tick();
    chk("mr_drained", 64'(q[2].size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
